// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: active-low segment codes (gfedcba, 0 = lit).
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/display_decoder_if.sv
// Producer-side handshake bundle for display_decoder: value load/ready plus blink request.
interface display_decoder_if #(
  parameter int N_DIGITS = 4
);

  logic                  load;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  ready;
  logic                  blink;

  modport master (output load, bcd_in, blink, input ready);
  modport slave  (input load, bcd_in, blink, output ready);

endinterface

// File: rtl/bcd_para_7seg.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal nibbles show a dash.
module bcd_para_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_decoder.sv
// Time-multiplexed common-anode 7-segment driver with shadow/active registers and frame-aligned commit.
// Optional whole-display blinking is built when DISPLAY_BLINK_EN is defined.
module display_decoder
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_decoder_if.slave     bus,
  output logic [6:0]           seg,
  output logic [N_DIGITS-1:0]  an
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BCD_W = 4 * N_DIGITS;

  logic [PS_W-1:0]     prescaler_q, prescaler_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCD_W-1:0]    shadow_q, shadow_d;
  logic [BCD_W-1:0]    active_q, active_d;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic                shown_q, shown_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic       accept;
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;

  assign tick      = (prescaler_q == PS_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == IDX_W'(N_DIGITS - 1));
  assign accept    = bus.load && ready_q;

  always_comb begin
    cur_nibble = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_nibble = active_q[k*4 +: 4];
    end
  end

  bcd_para_7seg u_dec (
    .bcd (cur_nibble),
    .seg (cur_seg)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int BC_W = $clog2(2 * BLINK_DIV);

  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blank_phase;

  // Frame counter only runs while blinking is requested, so blink always starts with a lit phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (!bus.blink) begin
      blink_cnt_d = '0;
    end else if (frame_end) begin
      blink_cnt_d = (blink_cnt_q == BC_W'(2 * BLINK_DIV - 1)) ? '0 : blink_cnt_q + BC_W'(1);
    end
  end

  assign blank_phase = bus.blink && (blink_cnt_q >= BC_W'(BLINK_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt_q <= '0;
    else        blink_cnt_q <= blink_cnt_d;
  end
`else
  logic blank_phase;
  logic blink_unused;

  assign blank_phase  = 1'b0;
  assign blink_unused = bus.blink;
`endif

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
    idx_d       = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    shown_d   = shown_q;

    // ready is low whenever pending is high, so accept and commit never fire together.
    if (accept) begin
      shadow_d  = bus.bcd_in;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end else if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
      shown_d   = 1'b1;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (shown_q) begin
      seg_d = cur_seg;
      for (int k = 0; k < N_DIGITS; k++) an_d[k] = (idx_q != IDX_W'(k));
    end
    if (blank_phase) an_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b1;
      shown_q     <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      shown_q     <= shown_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.ready = ready_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
